// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice: sizes and FSM state encoding.
package arb_pkg;
  localparam int ARB_N_MAX = 8;
  localparam int CNT_W     = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter int N     = 8,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             found
);

  logic [PTR_W:0]   shamt;
  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   win_dbl;
  logic [N-1:0]     rot;
  logic [N-1:0]     rot_win;

  // Rotate so bit ptr+1 lands at position 0, take the lowest set bit, rotate back.
  always_comb begin
    shamt   = {1'b0, ptr} + {{PTR_W{1'b0}}, 1'b1};
    req_dbl = {req, req} >> shamt;
    rot     = req_dbl[N-1:0];
    rot_win = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    win_dbl = {rot_win, rot_win} << shamt;
    win     = win_dbl[2*N-1:N];
    found   = |req;
  end

endmodule

// File: rtl/rr_arb8.sv
// Registered sticky round-robin arbiter with one-hot grant for the 8-to-3 encoder.
// Optional per-owner hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arb8 import arb_pkg::*; #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_busy,
  output logic         o_new_gnt
);

  localparam int PTR_W = $clog2(N);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_d;
  logic             new_d;
  logic [N-1:0]     pick_req;
  logic [N-1:0]     pick_win;
  logic             pick_found;
  logic             owner_req;
  logic             hold_expire;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

  assign owner_req = i_req[ptr_q];
  // The current owner is masked out so a forced handover never re-picks it.
  assign pick_req  = (state_q == ST_OWNED) ? (i_req & ~o_gnt) : i_req;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .win   (pick_win),
    .found (pick_found)
  );

`ifdef ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] hold_cnt_q;

  assign hold_expire = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  // Saturates at MAX_HOLD-1: expiry either hands over (clearing it) or holds steady.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_cnt_q <= '0;
    end else if (new_d) begin
      hold_cnt_q <= '0;
    end else if (state_q == ST_OWNED && owner_req && !hold_expire) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end
`else
  assign hold_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = o_gnt;
    ptr_d   = ptr_q;
    new_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_win;
          ptr_d   = onehot_idx(pick_win);
          new_d   = 1'b1;
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!owner_req || (hold_expire && pick_found)) begin
          if (pick_found) begin
            gnt_d = pick_win;
            ptr_d = onehot_idx(pick_win);
            new_d = 1'b1;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: grant, busy and new-grant pulse all change on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_W'(N - 1);
      o_gnt     <= '0;
      o_busy    <= 1'b0;
      o_new_gnt <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      o_gnt     <= gnt_d;
      o_busy    <= |gnt_d;
      o_new_gnt <= new_d;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_gnt) && (o_busy == |o_gnt));

  a_params : assert property (@(posedge i_clk)
    (N >= 2) && (N <= ARB_N_MAX) && (MAX_HOLD >= 1) && (MAX_HOLD <= 255));

endmodule

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 (hold-limit test runs when ARB_HOLD_LIMIT_EN is defined).
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       busy;
  logic       new_gnt;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_arb8 #(.N(8), .MAX_HOLD(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_new_gnt (new_gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req   = 8'h00;
    #1 rst_n = 1'b0;
    tick();
    n_cmp++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt: got %h want %h", gnt, 8'h00); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (new_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_new: got %b want 0", new_gnt); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL idle_gnt: got %h want %h", gnt, 8'h00); end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h04;
    tick();
    n_cmp++; if (gnt !== 8'h04) begin n_fail++; $display("FAIL single_gnt: got %h want %h", gnt, 8'h04); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (new_gnt !== 1'b1) begin n_fail++; $display("FAIL single_new: got %b want 1", new_gnt); end
    tick();
    n_cmp++; if (gnt !== 8'h04) begin n_fail++; $display("FAIL single_hold: got %h want %h", gnt, 8'h04); end
    n_cmp++; if (new_gnt !== 1'b0) begin n_fail++; $display("FAIL single_new_pulse: got %b want 0", new_gnt); end
    req = 8'h00;
    tick();
    n_cmp++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL single_release: got %h want %h", gnt, 8'h00); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release_busy: got %b want 0", busy); end
    // A lone requester may win again after going idle.
    req = 8'h04;
    tick();
    n_cmp++; if (gnt !== 8'h04 || new_gnt !== 1'b1) begin n_fail++; $display("FAIL single_regrant: got %h/%b want 04/1", gnt, new_gnt); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      n_cmp++; if (gnt !== exp_gnt || new_gnt !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rot_first[%0d]: got %h/%b/%b want %h/1/1", k, gnt, new_gnt, busy, exp_gnt); end
      req = 8'hFF;
      tick();
      n_cmp++; if (gnt !== exp_gnt || new_gnt !== 1'b0) begin n_fail++; $display("FAIL rot_second[%0d]: got %h/%b want %h/0", k, gnt, new_gnt, exp_gnt); end
      req = 8'hFF & ~exp_gnt;
      tick();
    end
  endtask

  task automatic test_wraparound();
    do_reset();
    req = 8'h40;
    tick();
    n_cmp++; if (gnt !== 8'h40) begin n_fail++; $display("FAIL wrap_setup: got %h want %h", gnt, 8'h40); end
    req = 8'h21;
    tick();
    n_cmp++; if (gnt !== 8'h01 || new_gnt !== 1'b1) begin n_fail++; $display("FAIL wrap_first: got %h/%b want 01/1", gnt, new_gnt); end
    req = 8'h20;
    tick();
    n_cmp++; if (gnt !== 8'h20 || new_gnt !== 1'b1) begin n_fail++; $display("FAIL wrap_second: got %h/%b want 20/1", gnt, new_gnt); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h18;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (gnt !== 8'h08 || new_gnt !== 1'b0) begin n_fail++; $display("FAIL nopreempt[%0d]: got %h/%b want 08/0", i, gnt, new_gnt); end
    end
    req = 8'h00;
    tick();
    n_cmp++; if (gnt !== 8'h00 || busy !== 1'b0 || new_gnt !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %h/%b/%b want 00/0/0", gnt, busy, new_gnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    tick();
    n_cmp++; if (gnt !== 8'h10) begin n_fail++; $display("FAIL areset_setup: got %h want %h", gnt, 8'h10); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_clear: got %h/%b want 00/0", gnt, busy); end
    req = 8'h11;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 8'h01 || new_gnt !== 1'b1) begin n_fail++; $display("FAIL areset_restart: got %h/%b want 01/1", gnt, new_gnt); end
  endtask

`ifdef ARB_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'h03;
    tick();
    for (int c = 0; c < 16; c++) begin
      exp_gnt = ((c / 4) % 2 == 0) ? 8'h01 : 8'h02;
      n_cmp++; if (gnt !== exp_gnt || new_gnt !== (c % 4 == 0)) begin n_fail++; $display("FAIL hold_alt[%0d]: got %h/%b want %h/%b", c, gnt, new_gnt, exp_gnt, (c % 4 == 0)); end
      if (c < 15) tick();
    end
    req = 8'h01;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (gnt !== 8'h01) begin n_fail++; $display("FAIL hold_alone[%0d]: got %h want %h", i, gnt, 8'h01); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    req   = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_wraparound();
    test_no_preempt();
    test_async_reset();
`ifdef ARB_HOLD_LIMIT_EN
    test_hold_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Registered round-robin arbiter for N requesters (default 8).
- Produces a one-hot grant vector that feeds the 8-to-3 one-hot encoder directly downstream. The encoder converts it to a binary grant index plus an active flag.
- Grants are sticky: a grantee keeps the grant while its request stays high. On release, the grant moves to the next requester in rotating order without an idle bubble.

Parameters:
- N, 8, number of requesters (2..8; 8 matches the downstream encoder width).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner. Used only when ARB_HOLD_LIMIT_EN is defined; range 1..255.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  N  request per requester, level-sensitive.
- o_gnt  output  N  registered one-hot grant, or all-zero when idle.
- o_busy  output  1  registered; high when o_gnt is nonzero (equals |o_gnt).
- o_new_gnt  output  1  registered one-cycle pulse; high in the first cycle of each new grant, including handovers.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - o_gnt = 0, o_busy = 0, o_new_gnt = 0.
  - Last-grant pointer ptr = N-1, so requester 0 has highest priority first.
- FSM has two states, IDLE and OWNED.
- IDLE:
  - If i_req == 0, remain in IDLE; o_gnt stays 0.
  - Otherwise choose the winner: the first set bit of i_req searching ptr+1, ptr+2, … modulo N (wrap-around).
  - On the next edge: o_gnt = onehot(winner), ptr = winner, o_new_gnt = 1, state becomes OWNED.
  - Latency from request to grant is 1 cycle.
- OWNED, owner still requesting (i_req[ptr] == 1): hold o_gnt unchanged, o_new_gnt = 0. Other requests are ignored (no preemption).
- OWNED, owner released (i_req[ptr] == 0):
  - Same cycle, search the other requesters starting at ptr+1 (the owner bit is low, so it is excluded).
  - If a winner exists: on the next edge o_gnt = onehot(winner), ptr = winner, o_new_gnt = 1, remain in OWNED (zero-bubble handover).
  - If none: on the next edge o_gnt = 0, state becomes IDLE; ptr keeps its value.
- Owner drops and re-raises its request: it loses the grant when it drops. It regains the grant only by round-robin order, so the same requester can win again only if no other requester is pending.
- Invariants:
  - o_gnt is always zero or exactly one-hot; this is checked by assertion.
  - o_busy == |o_gnt in every cycle.
- Reset mid-grant: outputs clear immediately (asynchronously). After release, arbitration restarts from requester 0.
- Unused upper bits are not a concern, since N ≤ 8 and ports are exactly N wide. The integrator zero-extends to 8 bits at the encoder input when N < 8.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- When defined:
  - An 8-bit hold counter clears on every new grant and increments each OWNED cycle in which the owner keeps requesting.
  - When the counter reaches MAX_HOLD-1 and another requester is pending, the grant is forcibly handed over on the next edge, exactly as if the owner had released.
  - If no other requester is pending, the owner keeps the grant and the counter saturates.
- When undefined: no counter exists and grants are held indefinitely.

Decomposition:
- Shared package arb_pkg contains:
  - ARB_N_MAX = 8.
  - State encoding constants ST_IDLE = 1'b0 and ST_OWNED = 1'b1.
  - CNT_W = 8 for the hold counter.
- One combinational sub-module, rr_pick:
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner plus a found flag.
  - Implemented as a rotate, fixed-priority pick, then rotate back.
  - Reused by the main FSM for both the IDLE and the handover searches.

Test Plan:
- Reset then single request: i_req = 8'h04 → next cycle o_gnt = 8'h04, o_busy = 1, o_new_gnt pulses 1 cycle. The downstream encoder shows bin 2, active 1.
- Simultaneous requests from reset: i_req = 8'hFF held, each owner drops its bit for 1 cycle after 2 cycles of grant → grants visit 0x01, 0x02, …, 0x80, 0x01 in order with no idle cycle between owners.
- Wrap-around: ptr = 6 (grant 0x40 just released), i_req = 8'h21 → next grant 0x01, not 0x20; after 0x01 releases, the grant is 0x20.
- No preemption and release to idle: owner 0x08 holds while i_req = 8'h18 for 10 cycles → o_gnt stays 0x08. Then i_req = 0 → o_gnt = 0, o_busy = 0 one cycle later.
- Async reset mid-grant: assert i_rst_n = 0 between clock edges while o_gnt = 0x10 → o_gnt = 0 immediately. After release with i_req = 8'h11, the grant is 0x01.
- With ARB_HOLD_LIMIT_EN and MAX_HOLD = 4: i_req = 8'h03 held → grants alternate 0x01 and 0x02 every 4 cycles. With i_req = 8'h01 only, 0x01 is held indefinitely.
